mem_word_arbiter: RTL and testbench

Shares the single-port byte-wide data memory (32 x 8, synchronous write, combinational read) between the instruction-fetch port and the load/store port of the multicycle RISC-V core. Each granted request is sequenced as four consecutive byte accesses to move one 32-bit little-endian word. Arbitration between the two requesters is round-robin. The block sits between the core's fetch/LSU logic and the memory block.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_byte_sequencer.sv | 47 ++++
 rtl/mem_word_arbiter.sv | 113 +++++++++++
 tb/tb_mem_word_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the word arbiter
package mem_arb_pkg;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_CNT_W = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

endpackage

// File: rtl/mem_byte_sequencer.sv
// rtl/mem_byte_sequencer.sv - byte counter, wrapping address and write lane select
module mem_byte_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int WORD_BYTES = 4,
  parameter int CNT_W      = mem_arb_pkg::BYTE_CNT_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             active,
  input  logic                             we,
  input  logic [ADDR_WIDTH-1:0]            base,
  input  logic [WORD_BYTES*DATA_WIDTH-1:0] wdata,
  output logic [CNT_W-1:0]                 k,
  output logic                             last,
  output logic                             mem_write,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata
);

  logic [DATA_WIDTH-1:0] lane;

  assign last = (k == CNT_W'(WORD_BYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= '0;
    end else if (!active || last) begin
      k <= '0;
    end else begin
      k <= k + CNT_W'(1);
    end
  end

  always_comb begin
    lane = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (k == CNT_W'(i)) lane = wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Address addition is ADDR_WIDTH bits wide so a word straddling the top wraps to 0.
  assign mem_addr  = active ? base + ADDR_WIDTH'(k) : '0;
  assign mem_write = active && we;
  assign mem_wdata = (active && we) ? lane : '0;

endmodule

// File: rtl/mem_word_arbiter.sv
// rtl/mem_word_arbiter.sv - round-robin fetch/LSU arbiter moving 32-bit words over a byte memory
module mem_word_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int WORD_BYTES = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             if_req,
  input  logic [ADDR_WIDTH-1:0]            if_addr,
  output logic [WORD_BYTES*DATA_WIDTH-1:0] if_rdata,
  output logic                             if_ack,
  input  logic                             dm_req,
  input  logic                             dm_we,
  input  logic [ADDR_WIDTH-1:0]            dm_addr,
  input  logic [WORD_BYTES*DATA_WIDTH-1:0] dm_wdata,
  output logic [WORD_BYTES*DATA_WIDTH-1:0] dm_rdata,
  output logic                             dm_ack,
  output logic                             busy,
  output logic                             mem_write,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);
  import mem_arb_pkg::*;

  localparam int WW = WORD_BYTES * DATA_WIDTH;
  localparam int CW = $clog2(WORD_BYTES);

  state_t                state, nstate;
  logic                  gnt, last_gnt, pick, any_req, active, last;
  logic [ADDR_WIDTH-1:0] base;
  logic                  we_q;
  logic [WW-1:0]         wdata_q;
  logic [CW-1:0]         k;

  assign any_req = if_req | dm_req;
  assign active  = (state == XFER);
  assign busy    = (state == XFER) || (state == DONE);
  assign if_ack  = (state == DONE) && (gnt == GNT_IF);
  assign dm_ack  = (state == DONE) && (gnt == GNT_DM);

  // On a tie the requester that did not win last time gets the slot.
  always_comb begin
    pick = GNT_IF;
    if (if_req && dm_req) pick = (last_gnt == GNT_DM) ? GNT_IF : GNT_DM;
    else if (dm_req)      pick = GNT_DM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (any_req) nstate = XFER;
      XFER:    if (last) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt      <= GNT_IF;
      last_gnt <= GNT_DM;
      base     <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        gnt     <= pick;
        base    <= (pick == GNT_DM) ? dm_addr : if_addr;
        we_q    <= (pick == GNT_DM) && dm_we;
        wdata_q <= dm_wdata;
      end
      // Read bytes land directly in the granted port's register, lane k.
      if (active && !we_q) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
          if (k == CW'(i)) begin
            if (gnt == GNT_IF) if_rdata[i*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
            else               dm_rdata[i*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
          end
        end
      end
      if (state == DONE) last_gnt <= gnt;
    end
  end

  mem_byte_sequencer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .WORD_BYTES (WORD_BYTES),
    .CNT_W      (CW)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .active    (active),
    .we        (we_q),
    .base      (base),
    .wdata     (wdata_q),
    .k         (k),
    .last      (last),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

endmodule

// File: tb/tb_mem_word_arbiter.sv
// tb/tb_mem_word_arbiter.sv - directed and randomized checks of mem_word_arbiter against a word-level model
module tb_mem_word_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we, if_ack, dm_ack, busy, mem_write;
  logic [4:0]  if_addr, dm_addr, mem_addr;
  logic [31:0] if_rdata, dm_rdata, dm_wdata;
  logic [7:0]  mem_wdata, mem_rdata;

  logic [7:0]  mem [32];
  logic [7:0]  ref_mem [32];
  logic        tb_we;
  logic [4:0]  tb_addr;
  logic [7:0]  tb_data;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_if, exp_dm;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    else if (tb_we) mem[tb_addr] <= tb_data;
  end
  assign mem_rdata = mem[mem_addr];

  mem_word_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ack    (dm_ack),
    .busy      (busy),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [4:0] a);
    logic [31:0] w;
    logic [4:0]  ai;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      ai = a + 5'(i);
      w[8*i +: 8] = ref_mem[ai];
    end
    return w;
  endfunction

  task automatic preload(input logic [4:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    tick();
    tb_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic clear_reqs();
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
  endtask

  task automatic check_mem(input string tag, input logic [4:0] a);
    check(tag, 32'(mem[a]), 32'(ref_mem[a]));
  endtask

  // One complete word transfer from an idle arbiter; inputs are scrambled after grant.
  task automatic run_txn(input bit is_dm, input bit we, input logic [4:0] addr,
                         input logic [31:0] wd, input int drop_at);
    int         lat;
    bit         other_ack;
    logic [4:0] ea;
    logic [4:0] wa;
    if (is_dm) begin
      dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    lat = -1;
    other_ack = 1'b0;
    for (int c = 1; c <= 12 && lat < 0; c++) begin
      tick();
      if (c == 1) begin
        if (is_dm) begin
          dm_addr = 5'($urandom); dm_wdata = $urandom; dm_we = 1'($urandom);
        end else begin
          if_addr = 5'($urandom);
        end
      end
      if (c == drop_at) clear_reqs();
      if (c <= 4) begin
        ea = addr + 5'(c - 1);
        check("xfer_addr", 32'(mem_addr), 32'(ea));
        check("xfer_write", 32'(mem_write), 32'(we));
        check("xfer_busy", 32'(busy), 32'd1);
        if (we) check("xfer_wdata", 32'(mem_wdata), 32'(wd[8*(c-1) +: 8]));
      end
      if (is_dm ? dm_ack : if_ack) lat = c;
      if (is_dm ? if_ack : dm_ack) other_ack = 1'b1;
    end
    check("ack_latency", 32'(lat), 32'd5);
    check("other_ack_quiet", 32'(other_ack), 32'd0);
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        wa = addr + 5'(i);
        ref_mem[wa] = wd[8*i +: 8];
      end
    end else if (is_dm) begin
      exp_dm = ref_word(addr);
    end else begin
      exp_if = ref_word(addr);
    end
    check("if_rdata", if_rdata, exp_if);
    check("dm_rdata", dm_rdata, exp_dm);
    clear_reqs();
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_acks", 32'({if_ack, dm_ack}), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         nack;
    int         ack_cyc [3];
    bit         ack_dm [3];
    bit         re_if, re_dm;
    bit         is_dm, we;
    int         drop_at;

    rst = 1'b1;
    clear_reqs();
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    exp_if = '0; exp_dm = '0;
    tick();
    tick();
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_dm_rdata", dm_rdata, 32'd0);
    check("rst_if_ack", 32'(if_ack), 32'd0);
    check("rst_dm_ack", 32'(dm_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    rst = 1'b0;

    for (int a = 0; a < 32; a++) preload(5'(a), 8'($urandom));
    preload(5'd4, 8'h11); preload(5'd5, 8'h22); preload(5'd6, 8'h33); preload(5'd7, 8'h44);

    run_txn(1'b1, 1'b0, 5'd4, 32'd0, 0);
    check("load_word", dm_rdata, 32'h4433_2211);

    run_txn(1'b1, 1'b1, 5'd8, 32'hDEAD_BEEF, 0);
    check("store_b0", 32'(mem[8]), 32'hEF);
    check("store_b1", 32'(mem[9]), 32'hBE);
    check("store_b2", 32'(mem[10]), 32'hAD);
    check("store_b3", 32'(mem[11]), 32'hDE);
    run_txn(1'b0, 1'b0, 5'd8, 32'd0, 0);
    check("fetch_word", if_rdata, 32'hDEAD_BEEF);

    run_txn(1'b1, 1'b1, 5'd30, 32'h0102_0304, 0);
    check("wrap_30", 32'(mem[30]), 32'h04);
    check("wrap_31", 32'(mem[31]), 32'h03);
    check("wrap_0", 32'(mem[0]), 32'h02);
    check("wrap_1", 32'(mem[1]), 32'h01);

    run_txn(1'b1, 1'b0, 5'd20, 32'd0, 2);

    // Reset in the middle of a store: two bytes land, the rest do not.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 5'd12; dm_wdata = 32'hA1B2_C3D4;
    tick();
    tick();
    tick();
    check("midrst_k2_addr", 32'(mem_addr), 32'd14);
    rst = 1'b1;
    #1;
    check("midrst_write", 32'(mem_write), 32'd0);
    check("midrst_addr", 32'(mem_addr), 32'd0);
    check("midrst_wdata", 32'(mem_wdata), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_dm_ack", 32'(dm_ack), 32'd0);
    check("midrst_if_rdata", if_rdata, 32'd0);
    check("midrst_dm_rdata", dm_rdata, 32'd0);
    exp_if = '0; exp_dm = '0;
    clear_reqs();
    tick();
    rst = 1'b0;
    ref_mem[12] = 8'hD4;
    ref_mem[13] = 8'hC3;
    for (int a = 12; a < 16; a++) check_mem("midrst_mem", 5'(a));
    for (int c = 0; c < 6; c++) begin
      tick();
      check("midrst_no_ack", 32'({if_ack, dm_ack}), 32'd0);
    end
    run_txn(1'b1, 1'b0, 5'd12, 32'd0, 0);

    // Both requesters active out of reset, re-requesting right after each ack.
    rst = 1'b1;
    tick();
    if_req = 1'b1; if_addr = 5'd4;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 5'd8;
    exp_if = '0; exp_dm = '0;
    rst = 1'b0;
    nack = 0;
    ack_cyc = '{-1, -1, -1};
    ack_dm = '{1'b0, 1'b0, 1'b0};
    re_if = 1'b0; re_dm = 1'b0;
    for (int c = 1; c <= 30 && nack < 3; c++) begin
      tick();
      if (re_if) begin if_req = 1'b1; re_if = 1'b0; end
      if (re_dm) begin dm_req = 1'b1; re_dm = 1'b0; end
      if (if_ack && nack < 3) begin
        ack_cyc[nack] = c; ack_dm[nack] = 1'b0; nack++;
        check("cont_if_rdata", if_rdata, ref_word(5'd4));
        if_req = 1'b0; re_if = 1'b1;
      end
      if (dm_ack && nack < 3) begin
        ack_cyc[nack] = c; ack_dm[nack] = 1'b1; nack++;
        check("cont_dm_rdata", dm_rdata, ref_word(5'd8));
        dm_req = 1'b0; re_dm = 1'b1;
      end
    end
    clear_reqs();
    check("cont_nack", 32'(nack), 32'd3);
    check("cont_cyc0", 32'(ack_cyc[0]), 32'd5);
    check("cont_cyc1", 32'(ack_cyc[1]), 32'd11);
    check("cont_cyc2", 32'(ack_cyc[2]), 32'd17);
    check("cont_who0", 32'(ack_dm[0]), 32'd0);
    check("cont_who1", 32'(ack_dm[1]), 32'd1);
    check("cont_who2", 32'(ack_dm[2]), 32'd0);
    exp_if = ref_word(5'd4);
    exp_dm = ref_word(5'd8);
    tick();
    tick();
    check("cont_idle_busy", 32'(busy), 32'd0);

    for (int t = 0; t < 24; t++) begin
      is_dm = 1'($urandom);
      we = is_dm ? 1'($urandom) : 1'b0;
      drop_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_txn(is_dm, we, 5'($urandom), $urandom, drop_at);
    end

    for (int a = 0; a < 32; a++) check_mem("final_mem", 5'(a));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
